// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding unit for the 5-stage F/D/E/M/W pipeline; tracks its own E/M/W tags.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int NREAD  = 3,
  parameter int REGW   = 4,
  parameter int PC_REG = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_valid,
  input  logic [NREAD*REGW-1:0]   d_ra,
  input  logic [NREAD-1:0]        d_ra_used,
  input  logic                    d_wr_en,
  input  logic [REGW-1:0]         d_wa,
  input  logic                    d_load,
  input  logic                    d_pcwr,
  input  logic                    e_cond_ok,
  input  logic                    e_branch_taken,
  output logic                    stall_f,
  output logic                    stall_d,
  output logic                    flush_d,
  output logic                    flush_e,
  output logic [NREAD*2-1:0]      fwd_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             stat_stall_cnt,
  output logic [31:0]             stat_flush_cnt,
  output logic [31:0]             stat_fwd_cnt
`endif
);

  localparam logic [REGW-1:0] PCR = REGW'(PC_REG);

  logic                  r_te_v, r_te_wr, r_te_ld, r_te_pcwr;
  logic [REGW-1:0]       r_te_wa;
  logic [NREAD*REGW-1:0] r_te_ra;
  logic [NREAD-1:0]      r_te_used;
  logic                  r_tm_v, r_tm_wr, r_tm_ld, r_tm_pcwr;
  logic [REGW-1:0]       r_tm_wa;
  logic                  r_tw_v, r_tw_wr, r_tw_ld, r_tw_pcwr;
  logic [REGW-1:0]       r_tw_wa;

  logic [NREAD-1:0]      w_ldhit;
  logic [NREAD*2-1:0]    w_fwd;
  logic                  w_ldstall, w_pcwr_pend, w_flush_e;

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    logic [REGW-1:0] w_ra_d, w_ra_e;
    logic            w_mhit, w_whit;
    assign w_ra_d = d_ra[i*REGW +: REGW];
    assign w_ra_e = r_te_ra[i*REGW +: REGW];
    // Load-use check uses the unqualified E-stage write enable, so the stall is conservative
    assign w_ldhit[i] = d_ra_used[i] && (w_ra_d == r_te_wa) && (w_ra_d != PCR);
    assign w_mhit = r_tm_v && r_tm_wr && (w_ra_e == r_tm_wa) && (w_ra_e != PCR);
    assign w_whit = r_tw_v && r_tw_wr && (w_ra_e == r_tw_wa) && (w_ra_e != PCR);
    assign w_fwd[2*i +: 2] = !(r_te_v && r_te_used[i]) ? 2'b00 :
                             (w_mhit && !r_tm_ld)      ? 2'b10 :
                             w_whit                    ? 2'b01 : 2'b00;
  end

  assign w_ldstall   = r_te_v && r_te_ld && r_te_wr && d_valid && (|w_ldhit);
  assign w_pcwr_pend = (d_valid && d_pcwr) || (r_te_v && r_te_pcwr) || (r_tm_v && r_tm_pcwr);
  assign w_flush_e   = w_ldstall || e_branch_taken;

  assign stall_d = reset ? 1'b0 : w_ldstall;
  assign stall_f = reset ? 1'b0 : (w_ldstall || w_pcwr_pend);
  assign flush_e = reset ? 1'b1 : w_flush_e;
  assign flush_d = reset ? 1'b1 : (w_pcwr_pend || (r_tw_v && r_tw_pcwr) || e_branch_taken);
  assign fwd_sel = reset ? '0 : w_fwd;

  // Tags advance one stage per cycle; writes leaving E are qualified by the condition check
  always_ff @(posedge clk) begin
    if (reset) begin
      r_te_v    <= 1'b0;
      r_te_used <= '0;
      r_tm_v    <= 1'b0;
      r_tw_v    <= 1'b0;
    end else begin
      r_tw_v    <= r_tm_v;
      r_tw_wr   <= r_tm_wr;
      r_tw_wa   <= r_tm_wa;
      r_tw_ld   <= r_tm_ld;
      r_tw_pcwr <= r_tm_pcwr;
      r_tm_v    <= r_te_v;
      r_tm_wr   <= r_te_wr && e_cond_ok;
      r_tm_wa   <= r_te_wa;
      r_tm_ld   <= r_te_ld;
      r_tm_pcwr <= r_te_pcwr && e_cond_ok;
      if (!w_flush_e && d_valid) begin
        r_te_v    <= 1'b1;
        r_te_wr   <= d_wr_en;
        r_te_wa   <= d_wa;
        r_te_ld   <= d_load;
        r_te_pcwr <= d_pcwr;
        r_te_ra   <= d_ra;
        r_te_used <= d_ra_used;
      end else begin
        r_te_v    <= 1'b0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cnt <= '0;
      stat_flush_cnt <= '0;
      stat_fwd_cnt   <= '0;
    end else begin
      if (w_ldstall && stat_stall_cnt != 32'hFFFF_FFFF)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if ((e_branch_taken || w_pcwr_pend) && stat_flush_cnt != 32'hFFFF_FFFF)
        stat_flush_cnt <= stat_flush_cnt + 32'd1;
      if ((|w_fwd) && stat_fwd_cnt != 32'hFFFF_FFFF)
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule
